// File: rtl/uiq_pkg.sv
// Shared types and helpers for the unified issue queue: FU class codes, opcode decode, entry payload.
package uiq_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned PRF_W = 6;

  typedef enum logic [1:0] {
    FU_ALU = 2'b00,
    FU_BRU = 2'b01,
    FU_MUL = 2'b10,
    FU_LSU = 2'b11
  } fu_class_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [PRF_W-1:0] prs1;
    logic [PRF_W-1:0] prs2;
    logic [PRF_W-1:0] prd;
    logic             prd_v;
    logic             rdy1;
    logic             rdy2;
  } uiq_entry_t;

  // Only the major opcode is visible here, so OP-32 is the encoding routed to the multiplier.
  function automatic fu_class_e fu_class(input logic [OP_W-1:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: fu_class = FU_ALU;
      7'b1100011, 7'b1101111, 7'b1100111:             fu_class = FU_BRU;
      7'b0111011:                                     fu_class = FU_MUL;
      7'b0000011, 7'b0100011:                         fu_class = FU_LSU;
      default:                                        fu_class = FU_ALU;
    endcase
  endfunction

endpackage

// File: rtl/uiq_age_select.sv
// Oldest-request pick for one issue port: an entry wins when no other requester is older than it.
module uiq_age_select #(
  parameter int unsigned DEPTH = 16
) (
  input  logic [DEPTH-1:0]            req_i,
  input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
  output logic [DEPTH-1:0]            gnt_o,
  output logic [$clog2(DEPTH)-1:0]    idx_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic beats;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    beats = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      beats = req_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && req_i[j] && older_i[j][i]) beats = 1'b0;
      end
      gnt_o[i] = beats;
      if (beats) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/unified_issue_queue.sv
// Centralised issue queue: multi-lane dispatch, writeback/grant wakeup, per-port oldest-ready select.
module unified_issue_queue
  import uiq_pkg::*;
#(
  parameter int unsigned              DISP_NUM     = 4,
  parameter int unsigned              ISSUE_NUM    = 4,
  parameter int unsigned              WB_NUM       = 2,
  parameter int unsigned              DEPTH        = 16,
  parameter int unsigned              OPCODE       = OP_W,
  parameter int unsigned              PRF_WIDTH    = PRF_W,
  parameter logic [2*ISSUE_NUM-1:0]   PORT_CLASS   = 8'b11_10_00_00,
  parameter logic [ISSUE_NUM-1:0]     PORT_FAST_WK = 4'b0011
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [DISP_NUM-1:0]             disp_valid,
  input  logic [DISP_NUM*OPCODE-1:0]      disp_op,
  input  logic [DISP_NUM*PRF_WIDTH-1:0]   disp_prs1,
  input  logic [DISP_NUM*PRF_WIDTH-1:0]   disp_prs2,
  input  logic [DISP_NUM-1:0]             disp_prs1_v,
  input  logic [DISP_NUM-1:0]             disp_prs2_v,
  input  logic [DISP_NUM-1:0]             disp_prs1_rdy,
  input  logic [DISP_NUM-1:0]             disp_prs2_rdy,
  input  logic [DISP_NUM*PRF_WIDTH-1:0]   disp_prd,
  input  logic [DISP_NUM-1:0]             disp_prd_v,
  output logic                            disp_ready,
  input  logic [WB_NUM-1:0]               wb_valid,
  input  logic [WB_NUM*PRF_WIDTH-1:0]     wb_prd,
  input  logic [ISSUE_NUM-1:0]            iss_stall,
  output logic [ISSUE_NUM-1:0]            iss_valid,
  output logic [ISSUE_NUM*OPCODE-1:0]     iss_op,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0]  iss_prs1,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0]  iss_prs2,
  output logic [ISSUE_NUM*PRF_WIDTH-1:0]  iss_prd,
  output logic [ISSUE_NUM-1:0]            iss_prd_v,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned NPRF  = 2**PRF_WIDTH;

  logic [DEPTH-1:0]                   valid_q, valid_d;
  uiq_entry_t [DEPTH-1:0]             ent_q, ent_d;
  logic [DEPTH-1:0][DEPTH-1:0]        older_q, older_d;
  logic [CNT_W-1:0]                   occ_q, occ_d;

  logic [DEPTH-1:0]                   req;
  logic [DEPTH-1:0][1:0]              ent_cls;
  logic [ISSUE_NUM-1:0][DEPTH-1:0]    gnt_all;
  logic [ISSUE_NUM-1:0]               fast_v;
  logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0] fast_prd;
  logic [NPRF-1:0]                    wake_vec;

  logic [DEPTH-1:0]                   free, written, issued;
  int unsigned                        sel, wr_cnt, iss_cnt;
  logic                               hit;

  assign disp_ready = ((CNT_W'(DEPTH) - occ_q) >= CNT_W'(DISP_NUM)) & ~flush;
  assign occupancy  = occ_q;

  always_comb begin
    req     = '0;
    ent_cls = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i]     = valid_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
      ent_cls[i] = fu_class(ent_q[i].op);
    end
  end

  // Port p sees only requests that no lower-numbered port has already taken.
  for (genvar p = 0; p < ISSUE_NUM; p++) begin : g_port
    logic [DEPTH-1:0] avail, preq, gnt;
    logic [IDX_W-1:0] idx;

    if (p == 0) begin : g_first
      assign avail = req;
    end else begin : g_next
      assign avail = g_port[p-1].avail & ~g_port[p-1].gnt;
    end

    always_comb begin
      preq = '0;
      for (int i = 0; i < DEPTH; i++) begin
        preq[i] = avail[i] & (ent_cls[i] == PORT_CLASS[2*p +: 2]) & ~iss_stall[p];
      end
    end

    uiq_age_select #(.DEPTH(DEPTH)) u_sel (
      .req_i   (preq),
      .older_i (older_q),
      .gnt_o   (gnt),
      .idx_o   (idx)
    );

    assign gnt_all[p]                          = gnt;
    assign iss_valid[p]                        = (|gnt) & ~flush;
    assign iss_op[p*OPCODE +: OPCODE]          = ent_q[idx].op;
    assign iss_prs1[p*PRF_WIDTH +: PRF_WIDTH]  = ent_q[idx].prs1;
    assign iss_prs2[p*PRF_WIDTH +: PRF_WIDTH]  = ent_q[idx].prs2;
    assign iss_prd[p*PRF_WIDTH +: PRF_WIDTH]   = ent_q[idx].prd;
    assign iss_prd_v[p]                        = ent_q[idx].prd_v;
    assign fast_v[p]   = PORT_FAST_WK[p] & (|gnt) & ent_q[idx].prd_v;
    assign fast_prd[p] = ent_q[idx].prd;
  end

  always_comb begin
    wake_vec = '0;
    for (int w = 0; w < WB_NUM; w++) begin
      if (wb_valid[w]) wake_vec[wb_prd[w*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
    end
    for (int p = 0; p < ISSUE_NUM; p++) begin
      if (fast_v[p]) wake_vec[fast_prd[p]] = 1'b1;
    end
  end

  // Next state: wakeup, free on issue, then allocate lowest free entries in lane order.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    older_d = older_q;
    free    = ~valid_q;
    written = '0;
    issued  = '0;
    sel     = 0;
    hit     = 1'b0;
    wr_cnt  = 0;
    iss_cnt = 0;

    for (int i = 0; i < DEPTH; i++) begin
      if (wake_vec[ent_q[i].prs1]) ent_d[i].rdy1 = 1'b1;
      if (wake_vec[ent_q[i].prs2]) ent_d[i].rdy2 = 1'b1;
    end

    for (int p = 0; p < ISSUE_NUM; p++) issued = issued | gnt_all[p];
    for (int i = 0; i < DEPTH; i++) begin
      if (issued[i]) iss_cnt++;
    end
    valid_d = valid_d & ~issued;

    for (int k = 0; k < DISP_NUM; k++) begin
      if (disp_valid[k] && disp_ready) begin
        hit = 1'b0;
        sel = 0;
        for (int i = 0; i < DEPTH; i++) begin
          if (!hit && free[i]) begin
            sel = i;
            hit = 1'b1;
          end
        end
        ent_d[sel].op    = disp_op[k*OPCODE +: OPCODE];
        ent_d[sel].prs1  = disp_prs1[k*PRF_WIDTH +: PRF_WIDTH];
        ent_d[sel].prs2  = disp_prs2[k*PRF_WIDTH +: PRF_WIDTH];
        ent_d[sel].prd   = disp_prd[k*PRF_WIDTH +: PRF_WIDTH];
        ent_d[sel].prd_v = disp_prd_v[k];
        ent_d[sel].rdy1  = ~disp_prs1_v[k] | disp_prs1_rdy[k]
                         | wake_vec[disp_prs1[k*PRF_WIDTH +: PRF_WIDTH]];
        ent_d[sel].rdy2  = ~disp_prs2_v[k] | disp_prs2_rdy[k]
                         | wake_vec[disp_prs2[k*PRF_WIDTH +: PRF_WIDTH]];
        older_d[sel] = '0;
        for (int j = 0; j < DEPTH; j++) older_d[j][sel] = valid_q[j] | written[j];
        valid_d[sel] = 1'b1;
        free[sel]    = 1'b0;
        written[sel] = 1'b1;
        wr_cnt++;
      end
    end

    occ_d = occ_q + CNT_W'(wr_cnt) - CNT_W'(iss_cnt);

    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ent_q   <= '0;
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      older_q <= older_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_unified_issue_queue.sv
// Directed bench for unified_issue_queue: hand-computed expectations checked with immediate assertions.
module tb_unified_issue_queue;

  localparam int unsigned DN = 4;
  localparam int unsigned IN = 4;
  localparam int unsigned WN = 2;
  localparam int unsigned OW = 7;
  localparam int unsigned PW = 6;
  localparam int unsigned CW = 5;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_MUL = 7'b0111011;

  logic              clk, rst_n, flush;
  logic [DN-1:0]     disp_valid, disp_prs1_v, disp_prs2_v, disp_prs1_rdy, disp_prs2_rdy, disp_prd_v;
  logic [DN*OW-1:0]  disp_op;
  logic [DN*PW-1:0]  disp_prs1, disp_prs2, disp_prd;
  logic              disp_ready;
  logic [WN-1:0]     wb_valid;
  logic [WN*PW-1:0]  wb_prd;
  logic [IN-1:0]     iss_stall, iss_valid, iss_prd_v;
  logic [IN*OW-1:0]  iss_op;
  logic [IN*PW-1:0]  iss_prs1, iss_prs2, iss_prd;
  logic [CW-1:0]     occupancy;

  int total, bad;

  unified_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_prs1_v(disp_prs1_v), .disp_prs2_v(disp_prs2_v),
    .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
    .disp_prd(disp_prd), .disp_prd_v(disp_prd_v), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_prd(wb_prd), .iss_stall(iss_stall),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_prs1(iss_prs1), .iss_prs2(iss_prs2),
    .iss_prd(iss_prd), .iss_prd_v(iss_prd_v), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] prd_of(input int p);
    return iss_prd[p*PW +: PW];
  endfunction

  task automatic clr();
    flush = 0; disp_valid = '0; disp_op = '0; disp_prs1 = '0; disp_prs2 = '0;
    disp_prs1_v = '0; disp_prs2_v = '0; disp_prs1_rdy = '0; disp_prs2_rdy = '0;
    disp_prd = '0; disp_prd_v = '0; wb_valid = '0; wb_prd = '0; iss_stall = '0;
  endtask

  // Source mode: 0 unused, 1 busy (waits for wakeup), 2 ready per busy table.
  task automatic lane(input int k, input logic [6:0] op, input logic [5:0] s1, input int m1,
                      input logic [5:0] s2, input int m2, input logic [5:0] d);
    disp_valid[k] = 1'b1;
    disp_op[k*OW +: OW] = op;
    disp_prs1[k*PW +: PW] = s1;
    disp_prs1_v[k] = (m1 != 0);
    disp_prs1_rdy[k] = (m1 == 2);
    disp_prs2[k*PW +: PW] = s2;
    disp_prs2_v[k] = (m2 != 0);
    disp_prs2_rdy[k] = (m2 == 2);
    disp_prd[k*PW +: PW] = d;
    disp_prd_v[k] = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk); #1; clr();
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; clr();
    #3;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    @(negedge clk); rst_n = 1'b1;

    // 1: four ready ALU ops drain two per cycle, oldest first
    nxt();
    for (int k = 0; k < 4; k++) lane(k, OP_ALU, 6'd0, 0, 6'd0, 0, 6'(k + 1));
    settle();
    chk("t1_disp_ready", 32'(disp_ready), 1);
    chk("t1_empty_iss", 32'(iss_valid), 0);
    nxt(); settle();
    chk("t1_occ4", 32'(occupancy), 4);
    chk("t1_iss_a", 32'(iss_valid), 32'h3);
    chk("t1_p0_prd_a", 32'(prd_of(0)), 1);
    chk("t1_p1_prd_a", 32'(prd_of(1)), 2);
    chk("t1_p0_op", 32'(iss_op[6:0]), 32'(OP_ALU));
    nxt(); settle();
    chk("t1_occ2", 32'(occupancy), 2);
    chk("t1_iss_b", 32'(iss_valid), 32'h3);
    chk("t1_p0_prd_b", 32'(prd_of(0)), 3);
    chk("t1_p1_prd_b", 32'(prd_of(1)), 4);
    nxt(); settle();
    chk("t1_occ0", 32'(occupancy), 0);
    chk("t1_iss_idle", 32'(iss_valid), 0);

    // 2: fill to 13 so fewer than four slots remain
    nxt();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) lane(k, OP_ALU, 6'd40, 1, 6'd0, 0, 6'd0);
      settle();
      chk("t2_fill_ready", 32'(disp_ready), 1);
      nxt();
    end
    lane(2, OP_ALU, 6'd41, 1, 6'd0, 0, 6'd45);
    settle();
    chk("t2_occ12", 32'(occupancy), 12);
    chk("t2_ready12", 32'(disp_ready), 1);
    nxt();
    wb_valid[0] = 1'b1; wb_prd[5:0] = 6'd41;
    settle();
    chk("t2_occ13", 32'(occupancy), 13);
    chk("t2_full_ready", 32'(disp_ready), 0);
    chk("t2_none_ready", 32'(iss_valid), 0);
    nxt(); settle();
    chk("t2_iss_one", 32'(iss_valid), 1);
    chk("t2_iss_prd", 32'(prd_of(0)), 45);
    chk("t2_still_full", 32'(disp_ready), 0);
    nxt(); settle();
    chk("t2_occ_after", 32'(occupancy), 12);
    chk("t2_ready_again", 32'(disp_ready), 1);
    nxt(); flush = 1'b1;
    settle();
    chk("t2_flush_ready", 32'(disp_ready), 0);
    nxt(); settle();
    chk("t2_flushed", 32'(occupancy), 0);

    // 3: writeback wakes a waiting entry and a same-cycle dispatch
    nxt();
    lane(0, OP_ALU, 6'd9, 1, 6'd0, 0, 6'd20);
    settle();
    nxt();
    wb_valid[0] = 1'b1; wb_prd[5:0] = 6'd9;
    lane(0, OP_ALU, 6'd9, 1, 6'd0, 0, 6'd21);
    settle();
    chk("t3_wait", 32'(iss_valid), 0);
    chk("t3_occ1", 32'(occupancy), 1);
    nxt(); settle();
    chk("t3_both", 32'(iss_valid), 32'h3);
    chk("t3_a_prd", 32'(prd_of(0)), 20);
    chk("t3_b_prd", 32'(prd_of(1)), 21);
    nxt(); settle();
    chk("t3_occ0", 32'(occupancy), 0);

    // 4: fast ALU grant wakes next cycle, MUL result waits for writeback
    nxt();
    lane(0, OP_ALU, 6'd5, 2, 6'd0, 0, 6'd12);
    lane(1, OP_ALU, 6'd12, 1, 6'd0, 0, 6'd22);
    lane(2, OP_MUL, 6'd0, 0, 6'd0, 0, 6'd13);
    lane(3, OP_ALU, 6'd0, 0, 6'd13, 1, 6'd23);
    settle();
    nxt(); settle();
    chk("t4_iss_t", 32'(iss_valid), 32'h5);
    chk("t4_p0_prd", 32'(prd_of(0)), 12);
    chk("t4_p2_prd", 32'(prd_of(2)), 13);
    chk("t4_p2_op", 32'(iss_op[20:14]), 32'(OP_MUL));
    nxt(); settle();
    chk("t4_fast_iss", 32'(iss_valid), 1);
    chk("t4_fast_prd", 32'(prd_of(0)), 22);
    chk("t4_occ2", 32'(occupancy), 2);
    nxt();
    wb_valid[1] = 1'b1; wb_prd[11:6] = 6'd13;
    settle();
    chk("t4_slow_wait", 32'(iss_valid), 0);
    chk("t4_occ1", 32'(occupancy), 1);
    nxt(); settle();
    chk("t4_slow_iss", 32'(iss_valid), 1);
    chk("t4_slow_prd", 32'(prd_of(0)), 23);
    nxt(); settle();
    chk("t4_occ0", 32'(occupancy), 0);

    // 5: stall on port 0, older op sits in the higher-numbered entry
    nxt();
    lane(0, OP_ALU, 6'd0, 0, 6'd0, 0, 6'd29);
    lane(1, OP_ALU, 6'd51, 1, 6'd0, 0, 6'd30);
    settle();
    nxt();
    wb_valid[0] = 1'b1; wb_prd[5:0] = 6'd51;
    settle();
    chk("t5_z_iss", 32'(iss_valid), 1);
    chk("t5_z_prd", 32'(prd_of(0)), 29);
    nxt();
    iss_stall = 4'b0011;
    lane(0, OP_ALU, 6'd0, 0, 6'd0, 0, 6'd31);
    settle();
    chk("t5_all_stalled", 32'(iss_valid), 0);
    chk("t5_occ1", 32'(occupancy), 1);
    nxt();
    iss_stall = 4'b0001;
    settle();
    chk("t5_port1_only", 32'(iss_valid), 32'h2);
    chk("t5_port1_oldest", 32'(prd_of(1)), 30);
    nxt(); settle();
    chk("t5_y_iss", 32'(iss_valid), 1);
    chk("t5_y_prd", 32'(prd_of(0)), 31);
    nxt(); settle();
    chk("t5_occ0", 32'(occupancy), 0);

    // 6: flush with ten entries while dispatching
    nxt();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) lane(k, OP_ALU, 6'd60, 1, 6'd0, 0, 6'd0);
      settle();
      nxt();
    end
    lane(0, OP_ALU, 6'd0, 0, 6'd0, 0, 6'd33);
    lane(1, OP_ALU, 6'd0, 0, 6'd0, 0, 6'd34);
    settle();
    nxt();
    flush = 1'b1;
    for (int k = 0; k < 4; k++) lane(k, OP_ALU, 6'd0, 0, 6'd0, 0, 6'd35);
    settle();
    chk("t6_occ10", 32'(occupancy), 10);
    chk("t6_flush_iss", 32'(iss_valid), 0);
    chk("t6_flush_ready", 32'(disp_ready), 0);
    nxt(); settle();
    chk("t6_occ0", 32'(occupancy), 0);
    chk("t6_iss_idle", 32'(iss_valid), 0);
    chk("t6_ready", 32'(disp_ready), 1);

    // asynchronous reset mid-fill
    nxt();
    for (int k = 0; k < 4; k++) lane(k, OP_ALU, 6'd60, 1, 6'd0, 0, 6'd0);
    settle();
    nxt(); #1;
    chk("rst_mid_occ4", 32'(occupancy), 4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_occ0", 32'(occupancy), 0);
    chk("rst_mid_iss", 32'(iss_valid), 0);
    chk("rst_mid_ready", 32'(disp_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    nxt(); settle();
    chk("rst_post_occ", 32'(occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
